// File: rtl/fm_ctrl_pkg.sv
// Shared widths, sweep state encoding and direction constants for the FM sweep sequencer.
package fm_ctrl_pkg;

   localparam int unsigned FM_FW = 48;
   localparam int unsigned FM_DW = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWELL = 2'd1,
      ST_STEP  = 2'd2
   } fm_state_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } fm_dir_e;

endpackage

// File: rtl/fm_next_freq.sv
// Combinational next tuning word with clamping to the stop word, plus end-of-sweep detect.
module fm_next_freq
   import fm_ctrl_pkg::*;
#(
   parameter int unsigned FW = FM_FW
)
(
   input  logic [FW-1:0] cur_i,
   input  logic [FW-1:0] stop_i,
   input  logic [FW-1:0] step_i,
   input  fm_dir_e       dir_i,
   output logic [FW-1:0] next_o,
   output logic          at_stop_o
);

   logic [FW:0] sum;
   logic [FW:0] diff;

   // Extra MSB carries the overflow (up) or borrow (down) so clamping never wraps.
   always_comb begin
      sum       = {1'b0, cur_i} + {1'b0, step_i};
      diff      = {1'b0, cur_i} - {1'b0, step_i};
      next_o    = stop_i;
      at_stop_o = (cur_i == stop_i);
      if (step_i != '0) begin
         if (dir_i == DIR_UP) begin
            if (!sum[FW] && (sum[FW-1:0] < stop_i)) begin
               next_o = sum[FW-1:0];
            end
         end else begin
            if (!diff[FW] && (diff[FW-1:0] > stop_i)) begin
               next_o = diff[FW-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/fm_sweep_ctrl.sv
// FM tuning-word sweep sequencer: steps start->stop with a per-word dwell and a load strobe.
// Optional macro FM_SWEEP_HOLD_EN adds a Hold input that freezes the dwell countdown.
module fm_sweep_ctrl
   import fm_ctrl_pkg::*;
#(
   parameter int unsigned FW = FM_FW,
   parameter int unsigned DW = FM_DW
)
(
   input  logic          Clock,
   input  logic          Reset,
   input  logic          Start,
   input  logic          Abort,
   input  logic          Cont,
`ifdef FM_SWEEP_HOLD_EN
   input  logic          Hold,
`endif
   input  logic [FW-1:0] F_Start,
   input  logic [FW-1:0] F_Stop,
   input  logic [FW-1:0] F_Step,
   input  logic [DW-1:0] Dwell,
   output logic [FW-1:0] Freq_Out,
   output logic          Freq_EN,
   output logic          Busy,
   output logic          Done
);

   localparam logic [DW-1:0] DW_ONE = {{(DW-1){1'b0}}, 1'b1};

   fm_state_e     state_q, state_d;
   fm_dir_e       dir_q,   dir_d;
   logic [FW-1:0] start_q, start_d;
   logic [FW-1:0] stop_q,  stop_d;
   logic [FW-1:0] step_q,  step_d;
   logic          cont_q,  cont_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [DW-1:0] cnt_q,   cnt_d;
   logic [FW-1:0] freq_q,  freq_d;
   logic          en_q,    en_d;
   logic          busy_q,  busy_d;
   logic          done_q,  done_d;

   logic [DW-1:0] dwell_eff;
   logic [FW-1:0] next_word;
   logic          at_stop;
   logic          hold;

`ifdef FM_SWEEP_HOLD_EN
   assign hold = Hold;
`else
   assign hold = 1'b0;
`endif

   assign dwell_eff = (Dwell == '0) ? DW_ONE : Dwell;

   fm_next_freq #(
      .FW (FW)
   ) u_next (
      .cur_i     (freq_q),
      .stop_i    (stop_q),
      .step_i    (step_q),
      .dir_i     (dir_q),
      .next_o    (next_word),
      .at_stop_o (at_stop)
   );

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      start_d = start_q;
      stop_d  = stop_q;
      step_d  = step_q;
      cont_d  = cont_q;
      dwell_d = dwell_q;
      cnt_d   = cnt_q;
      freq_d  = freq_q;
      en_d    = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (Start && !Abort) begin
               start_d = F_Start;
               stop_d  = F_Stop;
               step_d  = F_Step;
               cont_d  = Cont;
               dwell_d = dwell_eff;
               dir_d   = (F_Stop >= F_Start) ? DIR_UP : DIR_DOWN;
               freq_d  = F_Start;
               en_d    = 1'b1;
               cnt_d   = dwell_eff - DW_ONE;
               state_d = ST_DWELL;
            end
         end

         ST_DWELL: begin
            if (Abort) begin
               state_d = ST_IDLE;
            end else if (!hold) begin
               if (cnt_q == '0) begin
                  state_d = ST_STEP;
               end else begin
                  cnt_d = cnt_q - DW_ONE;
               end
            end
         end

         ST_STEP: begin
            if (Abort) begin
               state_d = ST_IDLE;
            end else if (at_stop && !cont_q) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               freq_d  = at_stop ? start_q : next_word;
               en_d    = 1'b1;
               cnt_d   = dwell_q - DW_ONE;
               state_d = ST_DWELL;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_UP;
         start_q <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         cont_q  <= 1'b0;
         dwell_q <= '0;
         cnt_q   <= '0;
         freq_q  <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         start_q <= start_d;
         stop_q  <= stop_d;
         step_q  <= step_d;
         cont_q  <= cont_d;
         dwell_q <= dwell_d;
         cnt_q   <= cnt_d;
         freq_q  <= freq_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Freq_Out = freq_q;
   assign Freq_EN  = en_q;
   assign Busy     = busy_q;
   assign Done     = done_q;

endmodule
